// File: rtl/shared_vc_alloc.sv
`timescale 1ns/1ps
// Shared VC buffer pool allocator: one round-robin grant per cycle, with pool and
// per-port occupancy tracking and credit-driven slot return.
module shared_vc_alloc #(
   parameter int num_ports    = 5,
   parameter int pool_depth   = 8,
   parameter int max_per_port = 4
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [num_ports-1:0]                           req_ip,
   input  logic [num_ports-1:0]                           free_ip,
   output logic [num_ports-1:0]                           gnt_ip,
   output logic [$clog2(pool_depth+1)-1:0]                pool_free,
   output logic [num_ports*$clog2(max_per_port+1)-1:0]    port_cnt,
   output logic                                           pool_empty,
   output logic                                           error
);

   localparam int unsigned P  = num_ports;
   localparam int unsigned D  = pool_depth;
   localparam int unsigned C  = max_per_port;
   localparam int          PW = $clog2(D + 1);
   localparam int          CW = $clog2(C + 1);
   localparam int          RW = (P > 1) ? $clog2(P) : 1;

   logic [PW-1:0] pool_free_q, pool_free_d;
   logic [CW-1:0] cnt_q [P];
   logic [CW-1:0] cnt_d [P];
   logic [RW-1:0] rr_q, rr_d;
   logic [P-1:0]  gnt_q, gnt_d;
   logic          error_q, error_d;

   logic [P-1:0]  elig;
   logic [P-1:0]  vfree;
   logic          win_vld;
   logic [RW-1:0] win;
   logic [RW-1:0] idx;
   int unsigned   idx_full;

   // Eligibility looks only at registered counts, so free_ip never reaches gnt_ip combinationally.
   always_comb begin
      elig  = '0;
      vfree = '0;
      for (int unsigned p = 0; p < P; p++) begin
         elig[p]  = req_ip[p] && (cnt_q[p] < CW'(C)) && (pool_free_q != '0);
         vfree[p] = free_ip[p] && (cnt_q[p] != '0);
      end
   end

   always_comb begin
      win_vld  = 1'b0;
      win      = '0;
      idx      = '0;
      idx_full = 0;
      for (int unsigned i = 0; i < P; i++) begin
         idx_full = int'(rr_q) + i;
         if (idx_full >= P) idx_full = idx_full - P;
         idx = RW'(idx_full);
         if (!win_vld && elig[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   always_comb begin
      gnt_d       = '0;
      rr_d        = rr_q;
      error_d     = error_q;
      pool_free_d = pool_free_q;
      for (int unsigned p = 0; p < P; p++) begin
         cnt_d[p] = cnt_q[p];
         if (vfree[p]) begin
            cnt_d[p]    = cnt_d[p] - CW'(1);
            pool_free_d = pool_free_d + PW'(1);
         end
         if (free_ip[p] && (cnt_q[p] == '0)) error_d = 1'b1;
      end
      // Frees are applied first; a same-cycle grant and free on one port then net to zero.
      if (win_vld) begin
         gnt_d[win]  = 1'b1;
         cnt_d[win]  = cnt_d[win] + CW'(1);
         pool_free_d = pool_free_d - PW'(1);
         rr_d        = (win == RW'(P - 1)) ? '0 : win + RW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pool_free_q <= PW'(D);
         rr_q        <= '0;
         gnt_q       <= '0;
         error_q     <= 1'b0;
         for (int unsigned p = 0; p < P; p++) cnt_q[p] <= '0;
      end else begin
         pool_free_q <= pool_free_d;
         rr_q        <= rr_d;
         gnt_q       <= gnt_d;
         error_q     <= error_d;
         for (int unsigned p = 0; p < P; p++) cnt_q[p] <= cnt_d[p];
      end
   end

   always_comb begin
      port_cnt = '0;
      for (int unsigned p = 0; p < P; p++) port_cnt[(P-1-p)*CW +: CW] = cnt_q[p];
   end

   assign gnt_ip     = gnt_q;
   assign pool_free  = pool_free_q;
   assign pool_empty = (pool_free_q == '0);
   assign error      = error_q;

endmodule

// File: tb/tb_shared_vc_alloc.sv
`timescale 1ns/1ps
// Randomized and directed bench for shared_vc_alloc, checked every cycle against
// a behavioural pool/arbiter model.
module tb_shared_vc_alloc;

   localparam int P  = 5;
   localparam int D  = 8;
   localparam int C  = 4;
   localparam int PW = $clog2(D + 1);
   localparam int CW = $clog2(C + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [P-1:0]     req_ip = '0;
   logic [P-1:0]     free_ip = '0;
   logic [P-1:0]     gnt_ip;
   logic [PW-1:0]    pool_free;
   logic [P*CW-1:0]  port_cnt;
   logic             pool_empty;
   logic             error;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   int         m_free;
   int         m_cnt [P];
   int         m_rr;
   logic [P-1:0] m_gnt;
   bit         m_err;

   shared_vc_alloc #(.num_ports(P), .pool_depth(D), .max_per_port(C)) dut (
      .clk(clk), .reset(rst_n), .req_ip(req_ip), .free_ip(free_ip),
      .gnt_ip(gnt_ip), .pool_free(pool_free), .port_cnt(port_cnt),
      .pool_empty(pool_empty), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int cnt_of(input int p);
      logic [P*CW-1:0] v;
      v = port_cnt;
      return int'(v[(P-1-p)*CW +: CW]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_free = D;
         m_rr   = 0;
         m_gnt  = '0;
         m_err  = 1'b0;
         for (int p = 0; p < P; p++) m_cnt[p] = 0;
      end else begin
         int w;
         w = -1;
         if (m_free > 0)
            for (int i = 0; i < P; i++) begin
               int q;
               q = (m_rr + i) % P;
               if (w < 0 && req_ip[q] && m_cnt[q] < C) w = q;
            end
         m_gnt = '0;
         for (int p = 0; p < P; p++)
            if (free_ip[p]) begin
               if (m_cnt[p] == 0) m_err = 1'b1;
               else begin
                  m_cnt[p]--;
                  m_free++;
               end
            end
         if (w >= 0) begin
            m_gnt[w] = 1'b1;
            m_cnt[w]++;
            m_free--;
            m_rr = (w + 1) % P;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_gnt", int'(gnt_ip), int'(m_gnt));
         chk("model_pool_free", int'(pool_free), m_free);
         chk("model_pool_empty", int'(pool_empty), int'(m_free == 0));
         chk("model_error", int'(error), int'(m_err));
         for (int p = 0; p < P; p++) chk("model_port_cnt", cnt_of(p), m_cnt[p]);
      end
   end

   task automatic check_reset_vals(input string nm);
      chk({nm, "_gnt"}, int'(gnt_ip), 0);
      chk({nm, "_pool_free"}, int'(pool_free), D);
      chk({nm, "_port_cnt"}, int'(port_cnt), 0);
      chk({nm, "_pool_empty"}, int'(pool_empty), 0);
      chk({nm, "_error"}, int'(error), 0);
   endtask

   initial begin
      int n;
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("reset_idle");

      // Round robin across all ports
      req_ip = 5'b11111;
      for (int k = 0; k < P; k++) begin
         @(negedge clk);
         chk("rr_order", int'(gnt_ip), 1 << k);
      end
      req_ip = '0;
      chk("rr_pool_free", int'(pool_free), 3);

      // Asynchronous reset with 5 slots held
      #3 rst_n = 1'b0;
      #1 check_reset_vals("async_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single port up to its cap
      req_ip = 5'b00100;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (gnt_ip == 5'b00100) n++;
      end
      req_ip = '0;
      chk("cap_grants", n, 4);
      chk("cap_port2", cnt_of(2), 4);
      chk("cap_pool_free", int'(pool_free), 4);
      chk("cap_no_grant", int'(gnt_ip), 0);

      // Exhaust the pool
      req_ip = 5'b11111;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (pool_free == '0) break;
      end
      chk("exhaust_pool_free", int'(pool_free), 0);
      chk("exhaust_pool_empty", int'(pool_empty), 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("exhaust_no_grant", int'(gnt_ip), 0);
      end

      // Free on port 1 while empty: slot visible next cycle, grant one later
      free_ip = 5'b00010;
      @(negedge clk);
      free_ip = '0;
      chk("free_pool_free", int'(pool_free), 1);
      chk("free_no_grant_yet", int'(gnt_ip), 0);
      @(negedge clk);
      chk("free_grant_port3", int'(gnt_ip), 5'b01000);
      chk("free_pool_after", int'(pool_free), 0);
      req_ip = '0;

      // Same-cycle grant and free on port 3
      free_ip = 5'b00001;
      @(negedge clk);
      chk("pre_same_pool", int'(pool_free), 1);
      req_ip  = 5'b01000;
      free_ip = 5'b01000;
      @(negedge clk);
      req_ip  = '0;
      free_ip = '0;
      chk("same_gnt", int'(gnt_ip), 5'b01000);
      chk("same_port3", cnt_of(3), 2);
      chk("same_pool", int'(pool_free), 1);

      // Free against a zero count
      free_ip = 5'b10000;
      @(negedge clk);
      chk("valid_free_port4", cnt_of(4), 0);
      chk("valid_free_no_err", int'(error), 0);
      @(negedge clk);
      free_ip = '0;
      chk("err_set", int'(error), 1);
      chk("err_pool_unchanged", int'(pool_free), 2);
      req_ip = 5'b10000;
      @(negedge clk);
      req_ip = '0;
      chk("err_grant_ok", int'(gnt_ip), 5'b10000);
      chk("err_pool_after", int'(pool_free), 1);
      @(negedge clk);
      chk("err_sticky", int'(error), 1);

      // Randomized traffic with a mid-run reset
      #3 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 800; k++) begin
         req_ip  = P'($urandom_range(0, 31));
         free_ip = P'($urandom & $urandom & $urandom);
         if (k == 400) begin
            #3 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      req_ip  = '0;
      free_ip = '0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
